sdrc_wb_traffic_gen: RTL

Synthesisable, parametrised Wishbone burst master that drives `sdrc_top` in place of a behavioural testcase. It writes a configurable number of LFSR-patterned bursts, then reads back the same region and checks the data. Errors are counted and the first failing address is captured. It sits between the test/CPU control registers and the controller's Wishbone slave port, for any SDR width (8/16/32).

---
 rtl/sdrc_tg_pkg.sv | 13 +
 rtl/sdrc_tg_lfsr.sv | 20 ++
 rtl/sdrc_wb_traffic_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sdrc_tg_pkg.sv
// sdrc_tg_pkg: shared state encoding, CTI codes and LFSR step for the Wishbone traffic generator.
package sdrc_tg_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_WR, ST_WR_GAP, ST_RD_LOAD, ST_RD, ST_RD_GAP, ST_DONE
    } tg_state_e;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction
endpackage

// File: rtl/sdrc_tg_lfsr.sv
// sdrc_tg_lfsr: 32-bit Galois pattern source, reloaded for readback so reads replay the write sequence.
module sdrc_tg_lfsr
    import sdrc_tg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        adv,
    input  logic [31:0] seed,
    output logic [31:0] state
);
    // an all-zero state would lock up, so a zero seed becomes 1
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= '0;
        else if (load)
            state <= (seed == '0) ? 32'h1 : seed;
        else if (adv)
            state <= lfsr_next(state);
endmodule

// File: rtl/sdrc_wb_traffic_gen.sv
// sdrc_wb_traffic_gen: Wishbone burst master writing LFSR bursts then reading them back and checking.
module sdrc_wb_traffic_gen
    import sdrc_tg_pkg::*;
#(
    parameter int APP_AW = 26,
    parameter int DW     = 32,
    parameter int BW     = DW / 8,
    parameter int MAX_BL = 16,
    parameter int BLW    = $clog2(MAX_BL) + 1,
    parameter int NBW    = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [APP_AW-1:0] cfg_base_addr,
    input  logic [BLW-1:0]    cfg_burst_len,
    input  logic [NBW-1:0]    cfg_num_bursts,
    input  logic [31:0]       cfg_seed,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       err_count,
    output logic [APP_AW-1:0] first_err_addr,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [BW-1:0]     wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);
    localparam logic [BLW-1:0] MAX_LEN = BLW'(MAX_BL);
    tg_state_e state, state_n;
    logic [BLW-1:0] len_q, len_n, beat_q, beat_n, cfg_len;
    logic [NBW-1:0] nb_q, nb_n, burst_q, burst_n;
    logic [31:0] seed_q, lfsr;
    logic [APP_AW-1:0] base_q, addr_n, fea_n;
    logic [15:0] cnt_n;
    logic [2:0] cti_n;
    logic err_n, acc, start_ok, last_beat, last_burst, mism, nxt_bus;

    assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
    assign cfg_len    = (cfg_burst_len > MAX_LEN) ? MAX_LEN : cfg_burst_len;
    assign acc        = wb_ack_i && wb_stb_o;
    assign last_beat  = beat_q == len_q - BLW'(1);
    assign last_burst = burst_q == nb_q - NBW'(1);
    assign mism       = state == ST_RD && acc && wb_dat_i != lfsr[DW-1:0];
    assign busy       = state != ST_IDLE && state != ST_DONE;
    assign done       = state == ST_DONE;
    assign wb_dat_o   = lfsr[DW-1:0];

    sdrc_tg_lfsr u_lfsr (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .load (start_ok || state == ST_RD_LOAD),
        .adv  (acc),
        .seed (state == ST_RD_LOAD ? seed_q : cfg_seed),
        .state(lfsr)
    );

    always_comb begin
        state_n = state;
        len_n   = len_q;
        nb_n    = nb_q;
        beat_n  = beat_q;
        burst_n = burst_q;
        addr_n  = wb_addr_o;
        err_n   = err | mism;
        cnt_n   = (mism && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
        fea_n   = (mism && !err) ? wb_addr_o : first_err_addr;
        case (state)
            ST_IDLE, ST_DONE: if (start_ok) begin
                len_n   = cfg_len;
                nb_n    = cfg_num_bursts;
                beat_n  = '0;
                burst_n = '0;
                addr_n  = cfg_base_addr;
                err_n   = 1'b0;
                cnt_n   = '0;
                fea_n   = '0;
                state_n = (cfg_len == '0 || cfg_num_bursts == '0) ? ST_DONE : ST_WR;
            end
            ST_WR, ST_RD: if (acc) begin
                addr_n  = wb_addr_o + APP_AW'(BW);
                beat_n  = last_beat ? '0 : beat_q + BLW'(1);
                burst_n = last_beat ? burst_q + NBW'(1) : burst_q;
                if (last_beat)
                    state_n = (state == ST_WR) ? (last_burst ? ST_RD_LOAD : ST_WR_GAP)
                                               : (last_burst ? ST_DONE : ST_RD_GAP);
            end
            ST_WR_GAP: state_n = ST_WR;
            ST_RD_LOAD: begin
                addr_n  = base_q;
                burst_n = '0;
                state_n = ST_RD;
            end
            ST_RD_GAP: state_n = ST_RD;
            default: state_n = ST_IDLE;
        endcase
    end

    // bus outputs are registered from the next-state view so they change only on clock edges
    assign nxt_bus = state_n == ST_WR || state_n == ST_RD;
    assign cti_n   = nxt_bus ? ((beat_n == len_n - BLW'(1)) ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            state          <= ST_IDLE;
            len_q          <= '0;
            nb_q           <= '0;
            beat_q         <= '0;
            burst_q        <= '0;
            base_q         <= '0;
            seed_q         <= '0;
            err            <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_addr_o      <= '0;
            wb_sel_o       <= '0;
            wb_cti_o       <= CTI_CLASSIC;
        end else begin
            state          <= state_n;
            len_q          <= len_n;
            nb_q           <= nb_n;
            beat_q         <= beat_n;
            burst_q        <= burst_n;
            err            <= err_n;
            err_count      <= cnt_n;
            first_err_addr <= fea_n;
            wb_cyc_o       <= nxt_bus;
            wb_stb_o       <= nxt_bus;
            wb_we_o        <= state_n == ST_WR;
            wb_addr_o      <= addr_n;
            wb_sel_o       <= '1;
            wb_cti_o       <= cti_n;
            if (start_ok) begin
                base_q <= cfg_base_addr;
                seed_q <= cfg_seed;
            end
        end
endmodule
